// File: rtl/fir_pkg.sv
// Shared sizing helpers and output rounding for the FIR filter.
// FIR_FILTER_SAT_EN selects saturating (defined) or wrapping output.
package fir_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int fir_tree_depth(int taps);
    return $clog2(taps);
  endfunction

  function automatic int fir_acc_w(int data_w, int coef_w, int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Round half up, shift out the fraction, then clamp or wrap to out_w.
  function automatic wide_t sat_round(wide_t acc, int frac, int out_w);
    wide_t r;
    wide_t hi;
    wide_t lo;
    r = (acc + (wide_t'(1) <<< (frac - 1))) >>> frac;
`ifdef FIR_FILTER_SAT_EN
    hi = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (out_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
`else
    hi = r <<< (WIDE_W - out_w);
    lo = hi >>> (WIDE_W - out_w);
    r = lo;
`endif
    return r;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise adder tree, one level per cycle.
// Odd tail elements ride through a level unchanged; valid tag in parallel.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int N_IN  = 11,
  parameter int IN_W  = 32,
  parameter int OUT_W = 36
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    valid_i,
  input  logic signed [IN_W-1:0]  data_i [N_IN],
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] sum_o
);

  localparam int D = fir_tree_depth(N_IN);

  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int N = (N_IN + (1 << l) - 1) >> l;
    logic signed [OUT_W-1:0] node [N];
    logic                    node_v;

    if (l == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_ext
        assign node[i] = OUT_W'(data_i[i]);
      end
      assign node_v = valid_i;
    end else begin : g_add
      localparam int NP = (N_IN + (1 << (l - 1)) - 1) >> (l - 1);
      logic signed [OUT_W-1:0] node_d [N];

      for (genvar i = 0; i < N; i++) begin : g_el
        if (2 * i + 1 < NP) begin : g_pair
          assign node_d[i] = g_lvl[l-1].node[2*i]
                           + g_lvl[l-1].node[2*i+1];
        end else begin : g_pass
          assign node_d[i] = g_lvl[l-1].node[2*i];
        end
      end

      // register one tree level and its valid tag
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          node   <= '{default: '0};
          node_v <= 1'b0;
        end else begin
          node   <= node_d;
          node_v <= clr_i ? 1'b0 : g_lvl[l-1].node_v;
        end
      end
    end
  end

  assign sum_o   = g_lvl[D].node[0];
  assign valid_o = g_lvl[D].node_v;

endmodule

// File: rtl/fir_filter_param.sv
// Pipelined direct-form FIR with writable coefficients and flush.
// FIR_FILTER_SAT_EN: saturate the output; otherwise it wraps.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = 11,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int OUT_W     = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        valid_i,
  input  logic signed [DATA_W-1:0]    data_i,
  input  logic                        clear_i,
  input  logic                        coef_we_i,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr_i,
  input  logic signed [COEF_W-1:0]    coef_data_i,
  output logic                        valid_o,
  output logic signed [OUT_W-1:0]     data_o
);

  localparam int AW    = $clog2(NUM_TAPS);
  localparam int P_W   = DATA_W + COEF_W;
  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, NUM_TAPS);

  logic signed [DATA_W-1:0] tap_q  [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic signed [P_W-1:0]    prod_q [NUM_TAPS];
  logic                     vtap_q;
  logic                     vprod_q;
  logic signed [ACC_W-1:0]  tree_sum;
  logic                     tree_v;
  logic signed [OUT_W-1:0]  data_d;
  logic                     valid_o_q;
  logic signed [OUT_W-1:0]  data_o_q;

  // coefficient file; out-of-range addresses match no tap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coef_q <= '{default: '0};
    end else if (coef_we_i) begin
      for (int n = 0; n < NUM_TAPS; n++) begin
        if (coef_addr_i == AW'(n)) coef_q[n] <= coef_data_i;
      end
    end
  end

  // delay line shifts on accepted samples, flush wins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tap_q  <= '{default: '0};
      vtap_q <= 1'b0;
    end else if (clear_i) begin
      tap_q  <= '{default: '0};
      vtap_q <= 1'b0;
    end else begin
      vtap_q <= valid_i;
      if (valid_i) begin
        tap_q[0] <= data_i;
        for (int n = 1; n < NUM_TAPS; n++) begin
          tap_q[n] <= tap_q[n-1];
        end
      end
    end
  end

  // full-precision products, free running every cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q  <= '{default: '0};
      vprod_q <= 1'b0;
    end else begin
      vprod_q <= clear_i ? 1'b0 : vtap_q;
      for (int n = 0; n < NUM_TAPS; n++) begin
        prod_q[n] <= P_W'(tap_q[n]) * P_W'(coef_q[n]);
      end
    end
  end

  fir_adder_tree #(
    .N_IN  (NUM_TAPS),
    .IN_W  (P_W),
    .OUT_W (ACC_W)
  ) u_tree (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clear_i),
    .valid_i (vprod_q),
    .data_i  (prod_q),
    .valid_o (tree_v),
    .sum_o   (tree_sum)
  );

  assign data_d = OUT_W'(sat_round(wide_t'(tree_sum), FRAC_BITS, OUT_W));

  // output stage holds data until the next valid result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o_q <= 1'b0;
      data_o_q  <= '0;
    end else begin
      valid_o_q <= tree_v & ~clear_i;
      if (tree_v && !clear_i) data_o_q <= data_d;
    end
  end

  assign valid_o = valid_o_q;
  assign data_o  = data_o_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param (default parameters).
// Honors FIR_FILTER_SAT_EN to choose saturating or wrapping reference.
module tb_fir_filter_param;

  localparam int NT  = 11;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [15:0] data_i;
  logic        clear_i;
  logic        coef_we_i;
  logic [3:0]  coef_addr_i;
  logic [15:0] coef_data_i;
  logic        valid_o;
  logic [15:0] data_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int hist [NT];
  int mc [NT];
  logic [15:0] cbuf [NT];

  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;
  exp_t pend[$];
  logic [15:0] last_exp;

  bit          vrec [int];
  logic [15:0] drec [int];

  typedef struct {
    logic [15:0] c0;
    logic [15:0] d;
    logic [15:0] y;
  } vec_t;
  vec_t tbl [6];

  fir_filter_param dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .clear_i     (clear_i),
    .coef_we_i   (coef_we_i),
    .coef_addr_i (coef_addr_i),
    .coef_data_i (coef_data_i),
    .valid_o     (valid_o),
    .data_o      (data_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // y = round(sum(x*h) / 2^15), then clamp or keep low 16 bits
  function automatic logic [15:0] ref_out();
    longint acc;
    longint r;
    acc = 0;
    for (int n = 0; n < NT; n++) begin
      acc += longint'(hist[n]) * longint'(mc[n]);
    end
    r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_FILTER_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NT; n++) begin
      hist[n] = 0;
      mc[n] = 0;
    end
    pend.delete();
    last_exp = 16'h0000;
  endtask

  task automatic step(input bit v, input logic [15:0] d,
                      input bit clr = 1'b0, input bit we = 1'b0,
                      input logic [3:0] a = 4'd0,
                      input logic [15:0] cd = 16'h0);
    bit ev;
    valid_i = v;
    data_i = d;
    clear_i = clr;
    coef_we_i = we;
    coef_addr_i = a;
    coef_data_i = cd;
    @(posedge clk);
    cyc++;
    if (we && a < NT) mc[a] = int'($signed(cd));
    if (clr) begin
      for (int n = 0; n < NT; n++) hist[n] = 0;
      pend.delete();
    end else if (v) begin
      for (int n = NT - 1; n > 0; n--) hist[n] = hist[n-1];
      hist[0] = int'($signed(d));
      pend.push_back('{cyc + LAT, ref_out()});
    end
    #1;
    ev = (pend.size() > 0) && (pend[0].due == cyc);
    check("valid_o", {31'd0, valid_o}, {31'd0, ev});
    if (ev) begin
      last_exp = pend[0].val;
      void'(pend.pop_front());
    end
    check("data_o", {16'd0, data_o}, {16'd0, last_exp});
    vrec[cyc] = valid_o;
    drec[cyc] = data_o;
  endtask

  // flush, then write cbuf into every tap (tap0 written during the flush)
  task automatic load_coefs();
    step(1'b0, 16'h0, 1'b1, 1'b1, 4'd0, cbuf[0]);
    for (int n = 1; n < NT; n++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1, 4'(n), cbuf[n]);
    end
  endtask

  task automatic set_all(input logic [15:0] c);
    for (int n = 0; n < NT; n++) cbuf[n] = c;
    load_coefs();
  endtask

  task automatic set_one(input logic [15:0] c0);
    cbuf[0] = c0;
    for (int n = 1; n < NT; n++) cbuf[n] = 16'h0;
    load_coefs();
  endtask

  initial begin
    int s0;
    int cnt;
    int pat [7];
    logic [15:0] sat_exp;

    pat = '{1, 0, 0, 1, 1, 0, 1};
    tbl[0] = '{16'h0001, 16'h4000, 16'h0001};
    tbl[1] = '{16'h0001, 16'h3FFF, 16'h0000};
    tbl[2] = '{16'h4000, 16'h7FFF, 16'h4000};
    tbl[3] = '{16'h7FFF, 16'h8000, 16'h8001};
    tbl[4] = '{16'hC000, 16'h0001, 16'h0000};
    tbl[5] = '{16'hC000, 16'h0003, 16'hFFFF};

    rst_n = 1'b0;
    valid_i = 1'b0;
    data_i = '0;
    clear_i = 1'b0;
    coef_we_i = 1'b0;
    coef_addr_i = '0;
    coef_data_i = '0;
    model_reset();
    #12;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data", {16'd0, data_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single-tap rounding and sign vectors
    foreach (tbl[i]) begin
      set_one(tbl[i].c0);
      step(1'b1, tbl[i].d);
      repeat (LAT) step(1'b0, 16'h0);
      check("tbl_valid", {31'd0, valid_o}, 32'd1);
      check("tbl_y", {16'd0, data_o}, {16'd0, tbl[i].y});
    end

    // impulse through all-0.5 taps
    set_all(16'h4000);
    step(1'b1, 16'h7FFF);
    s0 = cyc;
    repeat (13) step(1'b1, 16'h0000);
    repeat (LAT) step(1'b0, 16'h0);
    cnt = 0;
    for (int c = s0; c <= s0 + 19; c++) begin
      if (vrec[c] && drec[c] == 16'h4000) cnt++;
    end
    check("imp_count", cnt, 11);
    check("imp_early", {31'd0, vrec[s0+LAT-1]}, 32'd0);
    check("imp_first", {31'd0, vrec[s0+LAT]}, 32'd1);
    check("imp_tail", {16'd0, drec[s0+17]}, 32'd0);

    // saturation, positive and negative
    for (int k = 0; k < 2; k++) begin
      set_all(16'h7FFF);
      repeat (NT) step(1'b1, (k == 0) ? 16'h7FFF : 16'h8000);
      repeat (LAT - 1) step(1'b0, 16'h0);
`ifdef FIR_FILTER_SAT_EN
      sat_exp = (k == 0) ? 16'h7FFF : 16'h8000;
`else
      sat_exp = last_exp;
`endif
      check("sat_y", {16'd0, data_o}, {16'd0, sat_exp});
    end

    // gapped strobe keeps its shape
    for (int n = 0; n < NT; n++) cbuf[n] = 16'($urandom);
    load_coefs();
    s0 = cyc + 1;
    for (int j = 0; j < 7; j++) step(pat[j] != 0, 16'($urandom));
    repeat (LAT + 2) step(1'b0, 16'h0);
    for (int j = 0; j < 7; j++) begin
      check("gap_v", {31'd0, vrec[s0+LAT+j]}, pat[j]);
    end

    // coefficient write in the same cycle as a sample
    set_one(16'h4000);
    step(1'b1, 16'h1000);
    s0 = cyc;
    step(1'b1, 16'h1000, 1'b0, 1'b1, 4'd0, 16'h2000);
    repeat (LAT + 1) step(1'b0, 16'h0);
    check("cw_old", {16'd0, drec[s0+LAT]}, 32'h0800);
    check("cw_new", {16'd0, drec[s0+LAT+1]}, 32'h0400);

    // flush with samples in flight
    set_all(16'h4000);
    repeat (3) step(1'b1, 16'h1234);
    step(1'b1, 16'h5555, 1'b1);
    s0 = cyc;
    repeat (LAT + 2) step(1'b0, 16'h0);
    cnt = 0;
    for (int c = s0; c <= cyc; c++) cnt += int'(vrec[c]);
    check("clr_none", cnt, 0);
    step(1'b1, 16'h7FFF);
    s0 = cyc;
    repeat (LAT) step(1'b0, 16'h0);
    check("clr_fresh", {16'd0, drec[s0+LAT]}, 32'h4000);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 16'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 15)), 16'($urandom));
    end

    // asynchronous reset mid-stream
    set_all(16'h4000);
    repeat (8) step(1'b1, 16'h1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_data", {16'd0, data_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s0 = cyc + 1;
    repeat (20) step(1'b1, 16'($urandom));
    cnt = 0;
    for (int c = s0; c <= cyc; c++) begin
      if (drec[c] != 16'h0000) cnt++;
    end
    check("arst_coef0", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_param.md
Name: fir_filter_param

Overview:
- Parametrised pipelined direct-form FIR filter; successor to the fixed 11-tap, 16-bit, truncating filter.
- Generic tap count and data/coefficient widths, signed full-precision arithmetic, and a runtime-writable coefficient register file.
- Adds a valid-tagged free-running pipeline, round-and-saturate output stage and a synchronous flush.
- Sits between the sample source (ADC/strobe domain logic) and downstream DSP in the same clock domain.

Parameters:
- NUM_TAPS, 11, number of taps (>=2).
- DATA_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width.
- OUT_W, 16, signed output width.
- FRAC_BITS, 15, fractional bits of the coefficients; right shift applied before output (>=1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  sample strobe; data_i accepted on each rising clk_i edge where high.
- data_i  in  DATA_W  signed input sample.
- clear_i  in  1  synchronous flush of delay line and in-flight pipeline.
- coef_we_i  in  1  coefficient write enable.
- coef_addr_i  in  $clog2(NUM_TAPS)  tap index to write.
- coef_data_i  in  COEF_W  signed coefficient value.
- valid_o  out  1  data_o is valid this cycle.
- data_o  out  OUT_W  signed filtered sample.

Behaviour:
- Reset, asynchronous and active-low: all delay-line taps, coefficients, products, tree registers and the valid pipeline clear to 0. Output reset values are valid_o=0 and data_o=0.
- Delay line: shifts only when valid_i=1. Tap0 takes data_i; tap n takes tap n-1.
- Pipeline stages, registered every cycle and not gated by valid_i:
  - product stage, p[n] = tap[n]*coef[n], width DATA_W+COEF_W;
  - D = $clog2(NUM_TAPS) pairwise adder-tree levels; an odd leftover element is registered through unchanged;
  - output stage.
- Accumulator width: ACC_W = DATA_W+COEF_W+D, with sign-extension at every level. No wrap is possible inside the tree.
- Output stage:
  - add 2^(FRAC_BITS-1), i.e. round half up;
  - arithmetic shift right by FRAC_BITS;
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Latency: valid_i accepted at edge k gives valid_o=1 and the result at edge k+D+2. Default D=4, so latency is 6.
- Valid tagging: valid_o comes from a (D+2)-bit shift register fed by valid_i. Back-to-back valid_i produces back-to-back valid_o. Gaps are preserved one-for-one.
- data_o holds its last value while valid_o=0.
- Coefficients:
  - A write at edge k updates coef[coef_addr_i] at edge k.
  - The product stage at edge k+1 uses the new value. A sample accepted at edge k therefore uses it; samples accepted at edge k-1 or earlier do not.
  - coef_addr_i >= NUM_TAPS: the write is ignored.
  - No write-while-valid restriction.
- clear_i at edge k:
  - delay line and valid shift register are zeroed; no valid_o follows for samples in flight;
  - coefficients retained;
  - a valid_i in the same cycle is discarded;
  - coef_we_i in the same cycle still takes effect.
- Reset mid-operation aborts all in-flight samples immediately. The first output after reset is clean because only zero history has been seen.

Optional Feature:
- Macro FIR_FILTER_SAT_EN.
- Defined: the output stage saturates as described above.
- Undefined: the output stage wraps, taking the low OUT_W bits after the rounding and shift. This saves comparators.
- Rounding is present in both builds.

Decomposition:
- Package fir_pkg holds:
  - function fir_acc_w(data_w, coef_w, taps), returning ACC_W;
  - function fir_tree_depth(taps);
  - round/saturate helper function sat_round(acc, frac, out_w).
- One sub-module, fir_adder_tree. Parameters: N_IN, IN_W, OUT_W. It is registered and pipelined with latency $clog2(N_IN) and carries a parallel valid tag; reset is asynchronous, active-low.
- Coefficient file, delay line, product stage and output stage stay in the top level.

Test Plan (all with defaults):
- Impulse: all coef=0x4000; data_i=0x7FFF with one valid, then 10 zeros -> 11 consecutive valid_o with data_o=0x4000, first one 6 cycles after the impulse, then 0x0000.
- Saturation: all coef=0x7FFF; 11 samples of 0x7FFF -> data_o=0x7FFF. Same test with 0x8000 -> data_o=0x8000. Without FIR_FILTER_SAT_EN, compare against the wrapped reference model.
- Rounding: coef[0]=0x0001, others 0; data_i=0x4000 -> data_o=0x0001 (0.5 LSB rounds up). data_i=0x3FFF -> data_o=0x0000.
- Gapped strobe: valid_i pattern 1,0,0,1,1,0,1 -> valid_o shows the identical pattern delayed 6 cycles, with values matching the golden convolution.
- Coef write concurrency: write coef[0]=0x2000 in the same cycle as sample A (0x1000), with the previous coef[0]=0x4000 and others 0 -> A outputs 0x0400. The sample accepted one cycle earlier (0x1000) outputs 0x0800.
- Clear/reset: assert clear_i with 3 samples in flight -> no valid_o for them, and the next impulse response shows no prior history. Assert rst_ni low mid-stream -> valid_o=0 and data_o=0 immediately (asynchronously), and all coefficients read back as zero by giving no response until they are rewritten.
